// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC engine: arctangent table, gain constant,
// mode encoding and controller state type.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Reciprocal of the CORDIC gain, 0.607253 in Q0.16.
    localparam logic [15:0] GAIN_K = 16'h9B75;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        COMP
    } state_t;

    // atan(2^-i) in Q2.16, rescaled to the fraction width of a Q2.(width-2) operand.
    function automatic logic signed [63:0] atan_q(input int i, input int width);
        logic signed [63:0] base;
        case (i)
            0:       base = 64'sh0C910;
            1:       base = 64'sh076B2;
            2:       base = 64'sh03EB7;
            3:       base = 64'sh01FD6;
            4:       base = 64'sh00FFB;
            5:       base = 64'sh007FF;
            default: begin
                if (i <= 16) begin
                    base = 64'sd1 <<< (16 - i);
                end else begin
                    base = 64'sd0;
                end
            end
        endcase
        if (width >= 18) begin
            return base <<< (width - 18);
        end else begin
            return base >>> (18 - width);
        end
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; the direction is chosen from z in
// rotation mode and from the sign of y in vectoring mode.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int IW = 20,
    parameter int SW = 4
) (
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] y,
    input  logic signed [IW-1:0] z,
    input  logic        [SW-1:0] shift,
    input  logic signed [IW-1:0] atan_i,
    input  logic                 mode,
    output logic signed [IW-1:0] x_next,
    output logic signed [IW-1:0] y_next,
    output logic signed [IW-1:0] z_next
);

    logic                 d_pos;
    logic signed [IW-1:0] x_shr;
    logic signed [IW-1:0] y_shr;

    // d = +1 drives z toward zero (rotation) or y toward zero (vectoring).
    assign d_pos = (mode == MODE_VEC) ? y[IW-1] : ~z[IW-1];

    assign x_shr = x >>> shift;
    assign y_shr = y >>> shift;

    assign x_next = d_pos ? (x - y_shr) : (x + y_shr);
    assign y_next = d_pos ? (y + x_shr) : (y - x_shr);
    assign z_next = d_pos ? (z - atan_i) : (z + atan_i);

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC core retiring ITERS_PER_CYCLE micro-rotations per clock.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensation cycle (x, y scaled by 1/K).
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int ITERATIONS      = 12,
    parameter int ITERS_PER_CYCLE = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    // Two guard bits absorb the CORDIC gain and the angle accumulation.
    localparam int IW   = WIDTH + 2;
    localparam int IDXW = $clog2(ITERATIONS + 1);

    localparam logic signed [IW:0] SAT_MAX = $signed({{(IW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}});
    localparam logic signed [IW:0] SAT_MIN = $signed({{(IW - WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}});

    if ((ITERATIONS % ITERS_PER_CYCLE) != 0 ||
        (ITERS_PER_CYCLE != 1 && ITERS_PER_CYCLE != 2 && ITERS_PER_CYCLE != 4) ||
        ITERATIONS < 1 || ITERATIONS > WIDTH - 2) begin : g_param_check
        $error("cordic_engine: illegal ITERATIONS/ITERS_PER_CYCLE combination");
    end

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    state_t               state;
    state_t               state_next;
    logic                 load_op;
    logic                 step_op;
    logic                 finish_op;
    logic                 last_step;
    logic                 mode_r;
    logic [IDXW-1:0]      idx;
    logic signed [IW-1:0] x_r;
    logic signed [IW-1:0] y_r;
    logic signed [IW-1:0] z_r;

    logic signed [IW-1:0] xc [0:ITERS_PER_CYCLE];
    logic signed [IW-1:0] yc [0:ITERS_PER_CYCLE];
    logic signed [IW-1:0] zc [0:ITERS_PER_CYCLE];

    logic signed [WIDTH-1:0] x_fin;
    logic signed [WIDTH-1:0] y_fin;
    logic signed [WIDTH-1:0] z_fin;

    assign xc[0] = x_r;
    assign yc[0] = y_r;
    assign zc[0] = z_r;

    for (genvar k = 0; k < ITERS_PER_CYCLE; k++) begin : g_stage
        logic [IDXW-1:0]      shift_k;
        logic signed [IW-1:0] atan_k;

        assign shift_k = idx + IDXW'(k);
        assign atan_k  = IW'(atan_q(int'(shift_k), WIDTH));

        cordic_stage #(
            .IW (IW),
            .SW (IDXW)
        ) u_stage (
            .x      (xc[k]),
            .y      (yc[k]),
            .z      (zc[k]),
            .shift  (shift_k),
            .atan_i (atan_k),
            .mode   (mode_r),
            .x_next (xc[k+1]),
            .y_next (yc[k+1]),
            .z_next (zc[k+1])
        );
    end

    assign last_step = (idx == IDXW'(ITERATIONS - ITERS_PER_CYCLE));
    assign busy      = (state != IDLE);

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [IW+16:0] x_prod;
    logic signed [IW+16:0] y_prod;
    logic signed [IW:0]    x_scaled;
    logic signed [IW:0]    y_scaled;

    // Scaling happens on the registered iteration result during COMP.
    assign x_prod   = x_r * $signed({1'b0, GAIN_K});
    assign y_prod   = y_r * $signed({1'b0, GAIN_K});
    assign x_scaled = (IW + 1)'(x_prod >>> 16);
    assign y_scaled = (IW + 1)'(y_prod >>> 16);
    assign x_fin    = sat(x_scaled);
    assign y_fin    = sat(y_scaled);
    assign z_fin    = z_r[WIDTH-1:0];
`else
    assign x_fin = sat({xc[ITERS_PER_CYCLE][IW-1], xc[ITERS_PER_CYCLE]});
    assign y_fin = sat({yc[ITERS_PER_CYCLE][IW-1], yc[ITERS_PER_CYCLE]});
    assign z_fin = zc[ITERS_PER_CYCLE][WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start arriving on the result-update edge launches the next operation,
    // giving back-to-back throughput without an idle cycle.
    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        step_op    = 1'b0;
        finish_op  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_op    = 1'b1;
                    state_next = ITER;
                end
            end
            ITER: begin
                step_op = 1'b1;
                if (last_step) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = COMP;
`else
                    finish_op = 1'b1;
                    if (start) begin
                        load_op    = 1'b1;
                        state_next = ITER;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end
            end
            COMP: begin
                finish_op = 1'b1;
                if (start) begin
                    load_op    = 1'b1;
                    state_next = ITER;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_ROT;
            idx    <= '0;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            done   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            done <= finish_op;
            if (load_op) begin
                mode_r <= mode;
                idx    <= '0;
                x_r    <= {{2{x_in[WIDTH-1]}}, x_in};
                y_r    <= {{2{y_in[WIDTH-1]}}, y_in};
                z_r    <= {{2{z_in[WIDTH-1]}}, z_in};
            end else if (step_op) begin
                idx <= idx + IDXW'(ITERS_PER_CYCLE);
                x_r <= xc[ITERS_PER_CYCLE];
                y_r <= yc[ITERS_PER_CYCLE];
                z_r <= zc[ITERS_PER_CYCLE];
            end
            if (finish_op) begin
                x_out <= x_fin;
                y_out <= y_fin;
                z_out <= z_fin;
            end
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// Testbench for cordic_engine: random operations against an arithmetic CORDIC
// model, handshake/reset scenarios, and ITERS_PER_CYCLE 1/4 variants.
module tb_cordic_engine;

    localparam int W = 18;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 6 + EXTRA;
    // Ideal-value anchors tolerate the residual angle of 12 micro-rotations.
    localparam int TOL = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic mode;
    logic signed [W-1:0] x_in, y_in, z_in;

    logic busy, done;
    logic signed [W-1:0] x_out, y_out, z_out;
    logic busy_p1, done_p1;
    logic signed [W-1:0] x_out_p1, y_out_p1, z_out_p1;
    logic busy_p4, done_p4;
    logic signed [W-1:0] x_out_p4, y_out_p4, z_out_p4;

    int compared = 0;
    int mismatched = 0;

    int atan_tab [12] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32};

    cordic_engine #(.WIDTH(W), .ITERATIONS(12), .ITERS_PER_CYCLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    cordic_engine #(.WIDTH(W), .ITERATIONS(12), .ITERS_PER_CYCLE(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy_p1), .done(done_p1), .x_out(x_out_p1), .y_out(y_out_p1), .z_out(z_out_p1)
    );

    cordic_engine #(.WIDTH(W), .ITERATIONS(12), .ITERS_PER_CYCLE(4)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy_p4), .done(done_p4), .x_out(x_out_p4), .y_out(y_out_p4), .z_out(z_out_p4)
    );

    always #5 clk = ~clk;

    function automatic int sat18(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return int'(v);
    endfunction

    function automatic int wrap18(input longint v);
        longint t;
        t = v & 64'h3FFFF;
        if (t >= 131072) t = t - 262144;
        return int'(t);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rand18();
        int r;
        r = int'($urandom_range(0, 262143));
        return (r >= 131072) ? r - 262144 : r;
    endfunction

    // Reference: the micro-rotation equations evaluated with wide integers.
    function automatic void ref_model(input bit m, input int xi, input int yi, input int zi,
                                      output int xo, output int yo, output int zo);
        longint x, y, z, xn, yn;
        bit dpos;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < 12; i++) begin
            dpos = m ? (y < 0) : (z >= 0);
            xn = dpos ? x - (y >>> i) : x + (y >>> i);
            yn = dpos ? y + (x >>> i) : y - (x >>> i);
            z  = dpos ? z - atan_tab[i] : z + atan_tab[i];
            x = xn;
            y = yn;
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x * 39797) >>> 16;
        y = (y * 39797) >>> 16;
`endif
        xo = sat18(x);
        yo = sat18(y);
        zo = wrap18(z);
    endfunction

    task automatic drive(input bit m, input int xi, input int yi, input int zi);
        mode = m;
        x_in = W'(xi);
        y_in = W'(yi);
        z_in = W'(zi);
    endtask

    // Launches one operation and waits (bounded) for done; lat = 0 on timeout.
    task automatic run_op(input bit m, input int xi, input int yi, input int zi,
                          output int lat, output int xo, output int yo, output int zo);
        drive(m, xi, yi, zi);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; xo = 0; yo = 0; zo = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                xo = int'(x_out); yo = int'(y_out); zo = int'(z_out);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        compared++; if ({x_out, y_out, z_out} !== '0) begin mismatched++; $display("[TB] FAIL reset_outputs: got %h %h %h want 0", x_out, y_out, z_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_rotation();
        int lat, xo, yo, zo, ex, ey, ez, ax;
        ref_model(0, 65536, 0, 51472, ex, ey, ez);
        run_op(0, 65536, 0, 51472, lat, xo, yo, zo);
`ifdef CORDIC_GAIN_COMP_EN
        ax = 46341;
`else
        ax = 76314;
`endif
        compared++; if (lat != LAT) begin mismatched++; $display("[TB] FAIL rot_latency: got %0d want %0d", lat, LAT); end
        compared++; if (xo != ex || yo != ey || zo != ez) begin mismatched++; $display("[TB] FAIL rot_exact: got %0d %0d %0d want %0d %0d %0d", xo, yo, zo, ex, ey, ez); end
        compared++; if (iabs(xo - ax) > TOL || iabs(yo - ax) > TOL) begin mismatched++; $display("[TB] FAIL rot_anchor_xy: got %0d %0d want %0d +-%0d", xo, yo, ax, TOL); end
        compared++; if (iabs(zo) > TOL) begin mismatched++; $display("[TB] FAIL rot_anchor_z: got %0d want 0 +-%0d", zo, TOL); end
    endtask

    task automatic test_vectoring();
        int lat, xo, yo, zo, ex, ey, ez;
        ref_model(1, 65536, 65536, 0, ex, ey, ez);
        run_op(1, 65536, 65536, 0, lat, xo, yo, zo);
        compared++; if (lat != LAT) begin mismatched++; $display("[TB] FAIL vec_latency: got %0d want %0d", lat, LAT); end
        compared++; if (xo != ex || yo != ey || zo != ez) begin mismatched++; $display("[TB] FAIL vec_exact: got %0d %0d %0d want %0d %0d %0d", xo, yo, zo, ex, ey, ez); end
`ifdef CORDIC_GAIN_COMP_EN
        compared++; if (iabs(xo - 92682) > TOL) begin mismatched++; $display("[TB] FAIL vec_anchor_x: got %0d want 92682 +-%0d", xo, TOL); end
`else
        compared++; if (xo != 131071) begin mismatched++; $display("[TB] FAIL vec_saturate_x: got %0d want 131071", xo); end
`endif
        compared++; if (iabs(yo) > TOL) begin mismatched++; $display("[TB] FAIL vec_anchor_y: got %0d want 0 +-%0d", yo, TOL); end
        compared++; if (iabs(zo - 51472) > TOL) begin mismatched++; $display("[TB] FAIL vec_anchor_z: got %0d want 51472 +-%0d", zo, TOL); end
    endtask

    task automatic test_random();
        int lat, xo, yo, zo, ex, ey, ez, xi, yi, zi;
        bit m;
        for (int t = 0; t < 16; t++) begin
            m = 1'($urandom_range(0, 1));
            xi = rand18(); yi = rand18(); zi = rand18();
            ref_model(m, xi, yi, zi, ex, ey, ez);
            run_op(m, xi, yi, zi, lat, xo, yo, zo);
            compared++; if (lat != LAT) begin mismatched++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", t, lat, LAT); end
            compared++; if (xo != ex) begin mismatched++; $display("[TB] FAIL rand_x[%0d] mode %0d in %0d %0d %0d: got %0d want %0d", t, m, xi, yi, zi, xo, ex); end
            compared++; if (yo != ey) begin mismatched++; $display("[TB] FAIL rand_y[%0d] mode %0d in %0d %0d %0d: got %0d want %0d", t, m, xi, yi, zi, yo, ey); end
            compared++; if (zo != ez) begin mismatched++; $display("[TB] FAIL rand_z[%0d] mode %0d in %0d %0d %0d: got %0d want %0d", t, m, xi, yi, zi, zo, ez); end
        end
    endtask

    task automatic test_handshake();
        int lat;
        drive(0, 40000, -20000, 30000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL hs_busy_after_start: got %b want 1", busy); end
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        compared++; if (lat != LAT) begin mismatched++; $display("[TB] FAIL hs_latency: got %0d want %0d", lat, LAT); end
        @(posedge clk); #1;
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL hs_done_width: got %b want 0", done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL hs_busy_after_done: got %b want 0", busy); end
    endtask

    task automatic test_ignored_start();
        int lat, extra, xo, yo, zo, ex, ey, ez, xa, ya, za;
        xa = rand18(); ya = rand18(); za = rand18();
        ref_model(0, xa, ya, za, ex, ey, ez);
        drive(0, xa, ya, za);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; extra = 0; xo = 0; yo = 0; zo = 0;
        for (int n = 1; n <= 3 * LAT; n++) begin
            @(posedge clk); #1;
            if (n == 2 || n == 4) begin
                drive(1, rand18(), rand18(), rand18());
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                if (lat == 0) begin
                    lat = n; xo = int'(x_out); yo = int'(y_out); zo = int'(z_out);
                end else begin
                    extra++;
                end
            end
        end
        compared++; if (lat != LAT) begin mismatched++; $display("[TB] FAIL ign_latency: got %0d want %0d", lat, LAT); end
        compared++; if (xo != ex || yo != ey || zo != ez) begin mismatched++; $display("[TB] FAIL ign_result: got %0d %0d %0d want %0d %0d %0d", xo, yo, zo, ex, ey, ez); end
        compared++; if (extra != 0) begin mismatched++; $display("[TB] FAIL ign_extra_done: got %0d want 0", extra); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ign_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int xa, ya, za, xb, yb, zb, eax, eay, eaz, ebx, eby, ebz, early;
        bit mb;
        xa = rand18(); ya = rand18(); za = rand18();
        xb = rand18(); yb = rand18(); zb = rand18();
        mb = 1'($urandom_range(0, 1));
        ref_model(0, xa, ya, za, eax, eay, eaz);
        ref_model(mb, xb, yb, zb, ebx, eby, ebz);
        drive(0, xa, ya, za);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        early = 0;
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clk); #1;
            if (n < LAT && done) early++;
            if (n == LAT - 1) begin
                drive(mb, xb, yb, zb);
                start = 1'b1;
            end
        end
        start = 1'b0;
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_done_a: got %b want 1", done); end
        compared++; if (int'(x_out) != eax || int'(y_out) != eay || int'(z_out) != eaz) begin mismatched++; $display("[TB] FAIL b2b_result_a: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, eax, eay, eaz); end
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clk); #1;
            if (n < LAT && done) early++;
        end
        compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_done_b: got %b want 1", done); end
        compared++; if (int'(x_out) != ebx || int'(y_out) != eby || int'(z_out) != ebz) begin mismatched++; $display("[TB] FAIL b2b_result_b: got %0d %0d %0d want %0d %0d %0d", x_out, y_out, z_out, ebx, eby, ebz); end
        compared++; if (early != 0) begin mismatched++; $display("[TB] FAIL b2b_spurious_done: got %0d want 0", early); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, xo, yo, zo, ex, ey, ez, xi, yi, zi;
        run_op(0, 65536, 0, 51472, lat, xo, yo, zo);
        drive(1, 70000, 12345, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_ctrl: got busy %b done %b want 0 0", busy, done); end
        compared++; if ({x_out, y_out, z_out} !== '0) begin mismatched++; $display("[TB] FAIL mid_reset_outputs: got %h %h %h want 0", x_out, y_out, z_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xi = rand18(); yi = rand18(); zi = rand18();
        ref_model(0, xi, yi, zi, ex, ey, ez);
        run_op(0, xi, yi, zi, lat, xo, yo, zo);
        compared++; if (lat != LAT) begin mismatched++; $display("[TB] FAIL post_reset_latency: got %0d want %0d", lat, LAT); end
        compared++; if (xo != ex || yo != ey || zo != ez) begin mismatched++; $display("[TB] FAIL post_reset_result: got %0d %0d %0d want %0d %0d %0d", xo, yo, zo, ex, ey, ez); end
    endtask

    task automatic test_param_sweep();
        int l1, l2, l4, x1, y1, z1, x4, y4, z4, ex, ey, ez, xi, yi, zi;
        bit m;
        repeat (30) @(posedge clk); #1;
        for (int t = 0; t < 6; t++) begin
            m = 1'($urandom_range(0, 1));
            xi = rand18(); yi = rand18(); zi = rand18();
            ref_model(m, xi, yi, zi, ex, ey, ez);
            drive(m, xi, yi, zi);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            l1 = 0; l2 = 0; l4 = 0; x1 = 0; y1 = 0; z1 = 0; x4 = 0; y4 = 0; z4 = 0;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk); #1;
                if (done && l2 == 0) l2 = n;
                if (done_p1 && l1 == 0) begin l1 = n; x1 = int'(x_out_p1); y1 = int'(y_out_p1); z1 = int'(z_out_p1); end
                if (done_p4 && l4 == 0) begin l4 = n; x4 = int'(x_out_p4); y4 = int'(y_out_p4); z4 = int'(z_out_p4); end
                if (l1 != 0 && l2 != 0 && l4 != 0) break;
            end
            compared++; if (l1 != 12 + EXTRA) begin mismatched++; $display("[TB] FAIL ipc1_latency[%0d]: got %0d want %0d", t, l1, 12 + EXTRA); end
            compared++; if (l4 != 3 + EXTRA) begin mismatched++; $display("[TB] FAIL ipc4_latency[%0d]: got %0d want %0d", t, l4, 3 + EXTRA); end
            compared++; if (x1 != ex || y1 != ey || z1 != ez) begin mismatched++; $display("[TB] FAIL ipc1_result[%0d]: got %0d %0d %0d want %0d %0d %0d", t, x1, y1, z1, ex, ey, ez); end
            compared++; if (x4 != ex || y4 != ey || z4 != ez) begin mismatched++; $display("[TB] FAIL ipc4_result[%0d]: got %0d %0d %0d want %0d %0d %0d", t, x4, y4, z4, ex, ey, ez); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_random();
        test_handshake();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
